// File: rtl/scc_mem_ctrl.sv
// Unified single-port memory controller arbitrating an instruction fetch port
// and a data port. Each access takes WAIT_STATES+2 cycles and ends in a
// one-cycle ack. Misaligned or out-of-range requests raise sticky error flags.
module scc_mem_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DATA_PRIO   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              halt_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              busy,
    output logic [1:0]        err_bits
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               own_d;
    logic               lat_we;
    logic [IDX_W-1:0]   lat_idx;
    logic [DATA_W-1:0]  lat_wdata;
    logic               lat_mis;
    logic               lat_oor;

    logic               if_cand, d_cand, accept, grant_d;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_mis, sel_oor;
    logic [IDX_W-1:0]   sel_idx;

    logic               if_ack_nxt, d_ack_nxt, busy_nxt, mem_we;
    logic [DATA_W-1:0]  rd_word, if_rdata_nxt, d_rdata_nxt;
    logic [1:0]         err_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];

    // A port is not re-accepted during its own ack cycle: its request is still held there
    assign if_cand  = if_req & ~if_ack;
    assign d_cand   = d_req & ~d_ack;
    assign grant_d  = (DATA_PRIO != 0) ? d_cand : (d_cand & ~if_cand);
    assign accept   = (state == ST_IDLE) & ~halt_f & (if_cand | d_cand);
    assign sel_addr = grant_d ? d_addr : if_addr;
    assign sel_idx  = sel_addr[OFF_W+IDX_W-1:OFF_W];

    // Address checks: low byte-offset bits must be zero, bits above the word index must be zero
    generate
        if (OFF_W > 0) begin : g_mis
            assign sel_mis = |sel_addr[OFF_W-1:0];
        end else begin : g_no_mis
            assign sel_mis = 1'b0;
        end
        if (ADDR_W > OFF_W + IDX_W) begin : g_oor
            assign sel_oor = |sel_addr[ADDR_W-1:OFF_W+IDX_W];
        end else begin : g_no_oor
            assign sel_oor = 1'b0;
        end
    endgenerate

    // State register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (clk_en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the array write strobe
    always_comb begin
        rd_word      = mem[lat_idx];
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        err_nxt      = err_bits;
        mem_we       = 1'b0;
        busy_nxt     = (state_nxt != ST_IDLE);
        if (state == ST_RESP) begin
            err_nxt = err_bits | {lat_oor, lat_mis};
            if (own_d) begin
                d_ack_nxt = 1'b1;
                if (lat_we) mem_we = clk_en & ~lat_mis & ~lat_oor;
                else        d_rdata_nxt = (lat_mis | lat_oor) ? '0 : rd_word;
            end else begin
                if_ack_nxt   = 1'b1;
                if_rdata_nxt = (lat_mis | lat_oor) ? '0 : rd_word;
            end
        end
    end

    // Registered outputs and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err_bits  <= 2'b00;
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_mis   <= 1'b0;
            lat_oor   <= 1'b0;
        end else if (clk_en) begin
            busy     <= busy_nxt;
            if_ack   <= if_ack_nxt;
            d_ack    <= d_ack_nxt;
            if_rdata <= if_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
            err_bits <= err_nxt;
            if (accept) begin
                own_d     <= grant_d;
                lat_we    <= grant_d & d_we;
                lat_idx   <= sel_idx;
                lat_wdata <= d_wdata;
                lat_mis   <= sel_mis;
                lat_oor   <= sel_oor;
            end
        end
    end

    // Memory array, not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[lat_idx] <= lat_wdata;
    end

endmodule

// File: tb/tb_scc_mem_ctrl.sv
// Directed bench for scc_mem_ctrl with a reference memory model and
// per-port expected-response queues.
module tb_scc_mem_ctrl;

    localparam int unsigned WS = 1;

    logic        clk = 1'b0;
    logic        rst, clk_en, halt_f;
    logic        if_req, if_ack, d_req, d_we, d_ack, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  err_bits;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] mem_m [1024];
    logic [1:0]  err_m;
    logic [31:0] i_last, d_last;
    bit          i_ack_q, d_ack_q;

    always #5 clk = ~clk;

    scc_mem_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(WS), .DATA_PRIO(1)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy), .err_bits(err_bits)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model the expected response of a request and update the reference memory/error state
    function automatic exp_t model(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   mis, oor;
        mis = (a[1:0] != 2'b00);
        oor = (a[31:12] != 20'd0);
        err_m = err_m | {oor, mis};
        e.wr   = wr;
        e.data = 32'd0;
        if (wr) begin
            if (!mis && !oor) mem_m[a[11:2]] = wd;
        end else if (!mis && !oor) begin
            e.data = mem_m[a[11:2]];
        end
        return e;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " if_ack"},   32'(if_ack),   32'd0);
        check({tag, " d_ack"},    32'(d_ack),    32'd0);
        check({tag, " if_rdata"}, if_rdata,      32'd0);
        check({tag, " d_rdata"},  d_rdata,       32'd0);
        check({tag, " err_bits"}, 32'(err_bits), 32'd0);
    endtask

    // Scoreboard: compare read data (or unchanged data on a write ack) at each ack rising edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            i_last  = 32'd0;
            d_last  = 32'd0;
            i_ack_q = 1'b0;
            d_ack_q = 1'b0;
        end else begin
            if (if_ack && !i_ack_q) begin
                check("if_ack expected", 32'(if_q.size() != 0), 32'd1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata, e.data);
                    i_last = e.data;
                end
            end
            if (d_ack && !d_ack_q) begin
                check("d_ack expected", 32'(d_q.size() != 0), 32'd1);
                if (d_q.size() != 0) begin
                    e = d_q.pop_front();
                    if (e.wr) check("d_rdata held on write", d_rdata, d_last);
                    else begin
                        check("d_rdata", d_rdata, e.data);
                        d_last = e.data;
                    end
                end
            end
            i_ack_q = if_ack;
            d_ack_q = d_ack;
        end
    end

    // Issue requests, wait for their acks; optional clk_en stall and halt windows (k = negedges after issue)
    task automatic run(input bit do_i, input logic [31:0] ia,
                       input bit do_d, input bit we, input logic [31:0] da, input logic [31:0] wd,
                       input int stall_at, input int stall_len,
                       input int halt_at, input int halt_len,
                       output int t_i, output int t_d);
        int k;
        bit di, dd;
        k   = 0;
        di  = !do_i;
        dd  = !do_d;
        t_i = -1;
        t_d = -1;
        @(negedge clk);
        if (do_i) begin
            if_req = 1'b1; if_addr = ia;
            if_q.push_back(model(1'b0, ia, 32'd0));
        end
        if (do_d) begin
            d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd;
            d_q.push_back(model(we, da, wd));
        end
        while (!(di && dd) && k < 60) begin
            @(negedge clk);
            k++;
            if (!di && if_ack) begin di = 1'b1; t_i = k; if_req = 1'b0; end
            if (!dd && d_ack)  begin dd = 1'b1; t_d = k; d_req  = 1'b0; end
            if (stall_at >= 0 && k == 3) check("busy during stall", 32'(busy), 32'd1);
            if (halt_at >= 0 && k == halt_at + halt_len - 1) check("busy while halted", 32'(busy), 32'd0);
            if (k == stall_at) clk_en = 1'b0;
            if (k == stall_at + stall_len) clk_en = 1'b1;
            if (k == halt_at) halt_f = 1'b1;
            if (k == halt_at + halt_len) halt_f = 1'b0;
        end
        check("ack within budget", 32'(di && dd), 32'd1);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; clk_en = 1'b1; halt_f = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ti, td;
        bit seen;
        rst = 1'b1; clk_en = 1'b1; halt_f = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        err_m = 2'b00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Basic write then instruction fetch of the same word
        run(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, -1, 0, -1, 0, ti, td);
        check("write latency", 32'(td), 32'(WS + 2));
        run(1, 32'h10, 0, 0, 0, 0, -1, 0, -1, 0, ti, td);
        check("fetch latency", 32'(ti), 32'(WS + 2));

        // More patterns including the last word of the array
        run(0, 0, 1, 1, 32'h14, 32'hCAFEF00D, -1, 0, -1, 0, ti, td);
        run(0, 0, 1, 1, 32'hFFC, 32'hA5A50001, -1, 0, -1, 0, ti, td);
        run(0, 0, 1, 0, 32'h14, 0, -1, 0, -1, 0, ti, td);
        check("read latency", 32'(td), 32'(WS + 2));
        run(1, 32'hFFC, 0, 0, 0, 0, -1, 0, -1, 0, ti, td);
        run(0, 0, 1, 0, 32'hFFC, 0, -1, 0, -1, 0, ti, td);
        check("err_bits clean", 32'(err_bits), 32'(err_m));

        // Simultaneous requests: data port first, fetch one access period later
        run(1, 32'h14, 1, 0, 32'h10, 0, -1, 0, -1, 0, ti, td);
        check("prio d first", 32'(td), 32'(WS + 2));
        check("prio if spacing", 32'(ti - td), 32'(WS + 2));

        // Error handling: misaligned, then out of range; no wrap onto word 4
        run(0, 0, 1, 0, 32'h13, 0, -1, 0, -1, 0, ti, td);
        check("err misaligned", 32'(err_bits), 32'd1);
        run(0, 0, 1, 0, 32'h1000, 0, -1, 0, -1, 0, ti, td);
        check("err both", 32'(err_bits), 32'd3);
        check("err latency", 32'(td), 32'(WS + 2));
        run(0, 0, 1, 1, 32'h1010, 32'hFFFFFFFF, -1, 0, -1, 0, ti, td);
        run(0, 0, 1, 0, 32'h10, 0, -1, 0, -1, 0, ti, td);
        check("err sticky", 32'(err_bits), 32'd3);

        // clk_en low for 5 cycles during WAIT
        run(0, 0, 1, 1, 32'h18, 32'h0BADCAFE, 1, 5, -1, 0, ti, td);
        check("stall latency", 32'(td), 32'(WS + 2 + 5));
        run(0, 0, 1, 0, 32'h18, 0, -1, 0, -1, 0, ti, td);

        // halt_f raised after acceptance: in-flight completes, pending fetch waits for release
        run(1, 32'hFFC, 1, 0, 32'h14, 0, -1, 0, 1, 14, ti, td);
        check("halt inflight ack", 32'(td), 32'(WS + 2));
        check("halt pending ack", 32'(ti), 32'(15 + WS + 2));

        // Reset during a WAIT write aborts it
        run(0, 0, 1, 1, 32'h20, 32'h55AA55AA, -1, 0, -1, 0, ti, td);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(negedge clk);
        check("busy before abort", 32'(busy), 32'd1);
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        err_m = 2'b00;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | d_ack;
        end
        check("no ack after abort", 32'(seen), 32'd0);
        run(0, 0, 1, 0, 32'h20, 0, -1, 0, -1, 0, ti, td);
        check("err after reset", 32'(err_bits), 32'(err_m));
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
